load_store_unit: RTL and testbench

Core-side requester for `data_memory`. The core hands it one load or store at a time over a valid/ready handshake. It drives `data_memory`'s `address`, `write_data`, `MemRead`, `MemWrite` and `byte` ports, and returns the loaded data (extended to 32 bits) or a store completion. Halfword accesses are split into two byte accesses, because `data_memory` supports only byte and word transfers.

---
 rtl/load_store_unit_if.sv | 40 ++++
 rtl/load_store_unit.sv | 132 +++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data_memory bus for load_store_unit
interface load_store_unit_if;
    // core request
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // core response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    // data_memory side
    logic [31:0] address;
    logic [31:0] write_data;
    logic        MemRead;
    logic        MemWrite;
    logic        mem_byte;
    logic [31:0] read_data;

    // view of the load/store unit itself
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_fault,
        output address, write_data, MemRead, MemWrite, mem_byte,
        input  read_data
    );

    // view of the core plus data_memory driving the unit
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_fault,
        input  address, write_data, MemRead, MemWrite, mem_byte,
        output read_data
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store requester for data_memory
module load_store_unit #(
    parameter bit FAULT_ON_MISALIGN = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC0 = 2'd1;
    localparam logic [1:0] ACC1 = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    logic [1:0]  state;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        fault_q;
    logic [31:0] rdata_q;   // ACC0 read: whole word, or the low byte in [7:0]
    logic [7:0]  hi_q;      // ACC1 read: high byte of a halfword

    logic        accept;
    logic        req_fault;
    logic        in_acc;
    logic [31:0] word_addr;
    logic [31:0] load_result;

    assign accept = bus.req_valid && (state == IDLE);

    // Faults are decided on the live request so a faulting access never reaches memory
    assign req_fault = (bus.req_size == SIZE_BAD) ||
                       ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00) &&
                        FAULT_ON_MISALIGN);

    // Control FSM: IDLE -> ACC0 [-> ACC1] -> RESP, or IDLE -> RESP on a fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state <= req_fault ? RESP : ACC0;
                ACC0: state <= (size_q == SIZE_HALF) ? ACC1 : RESP;
                ACC1: state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    // Latch the whole request on accept so later req_* activity is invisible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            fault_q    <= 1'b0;
        end else if (accept) begin
            write_q    <= bus.req_write;
            size_q     <= bus.req_size;
            unsigned_q <= bus.req_unsigned;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
            fault_q    <= req_fault;
        end
    end

    // Capture load data at the end of each access cycle (memory reads are combinational)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'h0;
            hi_q    <= 8'h0;
        end else if (!write_q) begin
            if (state == ACC0) rdata_q <= bus.read_data;
            if (state == ACC1) hi_q    <= bus.read_data[7:0];
        end
    end

    // Memory outputs depend only on state and latched request, so they are glitch-free
    // with respect to req_*; a misaligned word only gets here when rounding is enabled.
    assign in_acc    = (state == ACC0) || (state == ACC1);
    assign word_addr = (size_q == SIZE_WORD) ? {addr_q[31:2], 2'b00} : addr_q;

    // Address and store-data steering for the current access cycle
    always_comb begin
        bus.address    = 32'h0;
        bus.write_data = 32'h0;
        case (state)
            ACC0: begin
                bus.address = word_addr;
                if (write_q)
                    bus.write_data = (size_q == SIZE_WORD) ? wdata_q : {24'h0, wdata_q[7:0]};
            end
            ACC1: begin
                bus.address = addr_q + 32'd1;
                if (write_q)
                    bus.write_data = {24'h0, wdata_q[15:8]};
            end
            default: ;
        endcase
    end

    assign bus.MemRead  = in_acc && !write_q;
    assign bus.MemWrite = in_acc && write_q;
    assign bus.mem_byte = in_acc && (size_q != SIZE_WORD);

    // Load result formatting: sign or zero extension from bit 7 or bit 15
    always_comb begin
        load_result = rdata_q;
        case (size_q)
            SIZE_BYTE: load_result = unsigned_q ? {24'h0, rdata_q[7:0]}
                                                : {{24{rdata_q[7]}}, rdata_q[7:0]};
            SIZE_HALF: load_result = unsigned_q ? {16'h0, hi_q, rdata_q[7:0]}
                                                : {{16{hi_q[7]}}, hi_q, rdata_q[7:0]};
            default:   load_result = rdata_q;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_fault = (state == RESP) && fault_q;
    assign bus.resp_rdata = ((state == RESP) && !fault_q && !write_q) ? load_result : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n;

    load_store_unit_if bus ();

    load_store_unit #(.FAULT_ON_MISALIGN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // byte memory indexed by address[7:0]; test addresses never alias
    logic [7:0] mem [0:255];
    logic [7:0] a8;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    end

    // combinational read; junk in the upper bits of byte reads
    always_comb begin
        a8 = bus.address[7:0];
        if (bus.mem_byte)
            bus.read_data = {24'hA5A5A5, mem[a8]};
        else
            bus.read_data = {mem[8'(a8 + 8'd3)], mem[8'(a8 + 8'd2)],
                             mem[8'(a8 + 8'd1)], mem[a8]};
    end

    // writes land at the edge ending the access cycle
    always @(posedge clk) begin
        if (bus.MemWrite) begin
            if (bus.mem_byte) begin
                mem[a8] <= bus.write_data[7:0];
            end else begin
                mem[a8]               <= bus.write_data[7:0];
                mem[8'(a8 + 8'd1)]    <= bus.write_data[15:8];
                mem[8'(a8 + 8'd2)]    <= bus.write_data[23:16];
                mem[8'(a8 + 8'd3)]    <= bus.write_data[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int          t_lat;
    logic [31:0] t_rd;
    logic        t_flt;
    int          t_nacc;
    logic        t_quiet;
    logic [31:0] acc_addr [2];
    logic [31:0] acc_wd   [2];
    logic        acc_byte [2];
    logic        acc_rd   [2];
    logic        acc_wr   [2];

    // issue one request at a negedge, follow it to the response, return in IDLE
    task automatic txn(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
        check("ready_before_req", {31'h0, bus.req_ready}, 32'h1);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_write    = ~w;
        bus.req_size     = 2'b11;
        bus.req_unsigned = ~uns;
        bus.req_addr     = 32'hCAFE0003;
        bus.req_wdata    = 32'h5555AAAA;
        t_lat  = 0;
        t_nacc = 0;
        t_rd   = 32'hX;
        t_flt  = 1'bX;
        t_quiet = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (bus.resp_valid) begin
                t_lat   = c;
                t_rd    = bus.resp_rdata;
                t_flt   = bus.resp_fault;
                t_quiet = !(bus.MemRead || bus.MemWrite || bus.mem_byte ||
                            (bus.address != 32'h0) || (bus.write_data != 32'h0));
                break;
            end
            if ((bus.MemRead || bus.MemWrite) && t_nacc < 2) begin
                acc_addr[t_nacc] = bus.address;
                acc_wd[t_nacc]   = bus.write_data;
                acc_byte[t_nacc] = bus.mem_byte;
                acc_rd[t_nacc]   = bus.MemRead;
                acc_wr[t_nacc]   = bus.MemWrite;
                t_nacc++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (t_lat == 0) check("resp_timeout", 32'h0, 32'h1);
        else            check("resp_mem_quiet", {31'h0, t_quiet}, 32'h1);
        @(posedge clk);
        @(negedge clk);
    endtask

    logic seen_resp;

    initial begin
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_req_ready",  {31'h0, bus.req_ready},  32'h1);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst_resp_rdata", bus.resp_rdata,          32'h0);
        check("rst_resp_fault", {31'h0, bus.resp_fault}, 32'h0);
        check("rst_address",    bus.address,             32'h0);
        check("rst_write_data", bus.write_data,          32'h0);
        check("rst_mem_ctrl",   {29'h0, bus.MemRead, bus.MemWrite, bus.mem_byte}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // SW 0x10 <- 0xDEADBEEF
        txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw_nacc",  t_nacc, 1);
        check("sw_addr",  acc_addr[0], 32'h10);
        check("sw_wdata", acc_wd[0], 32'hDEADBEEF);
        check("sw_ctrl",  {29'h0, acc_rd[0], acc_wr[0], acc_byte[0]}, 32'h2);
        check("sw_lat",   t_lat, 2);
        check("sw_fault", {31'h0, t_flt}, 32'h0);
        check("sw_rdata", t_rd, 32'h0);
        check("sw_mem",   {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);

        // LW 0x10
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_ctrl",  {29'h0, acc_rd[0], acc_wr[0], acc_byte[0]}, 32'h4);
        check("lw_rdata", t_rd, 32'hDEADBEEF);
        check("lw_lat",   t_lat, 2);

        // SB 0x21 <- 0x80, then LB / LBU
        txn(1'b1, 2'b00, 1'b0, 32'h21, 32'h12345680);
        check("sb_ctrl",  {29'h0, acc_rd[0], acc_wr[0], acc_byte[0]}, 32'h3);
        check("sb_wdata", acc_wd[0], 32'h00000080);
        check("sb_addr",  acc_addr[0], 32'h21);
        txn(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        check("lb_rdata",  t_rd, 32'hFFFFFF80);
        txn(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
        check("lbu_rdata", t_rd, 32'h00000080);

        // SH across the top of the address space
        txn(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'hABCD1234);
        check("sh_nacc",   t_nacc, 2);
        check("sh_addr0",  acc_addr[0], 32'hFFFFFFFF);
        check("sh_wdata0", acc_wd[0], 32'h00000034);
        check("sh_addr1",  acc_addr[1], 32'h00000000);
        check("sh_wdata1", acc_wd[1], 32'h00000012);
        check("sh_byte",   {30'h0, acc_byte[0], acc_byte[1]}, 32'h3);
        check("sh_lat",    t_lat, 3);
        check("sh_mem",    {16'h0, mem[8'h00], mem[8'hFF]}, 32'h00001234);
        txn(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
        check("lh_rdata",  t_rd, 32'h00001234);
        check("lh_lat",    t_lat, 3);

        // halfword sign extension
        txn(1'b1, 2'b01, 1'b0, 32'h40, 32'h00008001);
        txn(1'b0, 2'b01, 1'b0, 32'h40, 32'h0);
        check("lh_neg",    t_rd, 32'hFFFF8001);
        txn(1'b0, 2'b01, 1'b1, 32'h40, 32'h0);
        check("lhu_neg",   t_rd, 32'h00008001);

        // faults
        txn(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        check("mis_nacc",  t_nacc, 0);
        check("mis_lat",   t_lat, 1);
        check("mis_fault", {31'h0, t_flt}, 32'h1);
        check("mis_rdata", t_rd, 32'h0);
        txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        check("ill_nacc",  t_nacc, 0);
        check("ill_lat",   t_lat, 1);
        check("ill_fault", {31'h0, t_flt}, 32'h1);
        check("ill_rdata", t_rd, 32'h0);

        // reset in the middle of a halfword store
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b01;
        bus.req_addr  = 32'h50;
        bus.req_wdata = 32'h00005678;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rsh_acc0_addr", bus.address, 32'h50);
        @(posedge clk);
        @(negedge clk);
        check("rsh_acc1_wr", {31'h0, bus.MemWrite}, 32'h1);
        check("rsh_acc1_addr", bus.address, 32'h51);
        #2 rst_n = 1'b0;
        #1;
        check("rsh_memwrite_drop", {31'h0, bus.MemWrite}, 32'h0);
        check("rsh_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rsh_address", bus.address, 32'h0);
        seen_resp = bus.resp_valid;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.resp_valid) seen_resp = 1'b1;
            @(negedge clk);
        end
        check("rsh_no_resp", {31'h0, seen_resp}, 32'h0);
        check("rsh_mem", {16'h0, mem[8'h51], mem[8'h50]}, 32'h00000078);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("post_rst_lw", t_rd, 32'hDEADBEEF);
        check("post_rst_lat", t_lat, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
